// File: rtl/ioctl_upload_server_pkg.sv
// Shared definitions for the data_io upload path: slot indexes, pad byte,
// upload state encoding and the saturating byte-pointer increment.
package ioctl_upload_server_pkg;

    localparam logic [7:0] IOCTL_IDX_ROM   = 8'd0;
    localparam logic [7:0] IOCTL_IDX_NVRAM = 8'd4;
    localparam logic [7:0] PAD_BYTE        = 8'hFF;
    localparam int         PTR_W           = 25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } upl_state_t;

    // Pointer never runs past the slot size, so it cannot wrap back into memory.
    function automatic logic [PTR_W-1:0] ptr_sat_inc(input logic [PTR_W-1:0] p,
                                                     input logic [PTR_W-1:0] lim);
        return (p >= lim) ? lim : p + 25'd1;
    endfunction

endpackage

// File: rtl/ioctl_upload_server_if.sv
// Core memory read port used to prefetch upload bytes (req held until ack).
interface ioctl_upload_server_if #(
    parameter int AW = 12
) ();
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [7:0]    mem_data;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/ioctl_upload_server.sv
// Core-side responder for data_io uploads: prefetches one byte ahead from a
// core memory port into ioctl_din and pauses the core while the slot streams.
module ioctl_upload_server
    import ioctl_upload_server_pkg::*;
#(
    parameter logic [7:0] INDEX = IOCTL_IDX_NVRAM,
    parameter int         AW    = 12,
    parameter int         SIZE  = 4096,
    parameter logic [7:0] PAD   = PAD_BYTE
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  ioctl_upload,
    input  logic [7:0]            ioctl_index,
    input  logic                  ioctl_rd,
    output logic [7:0]            ioctl_din,
    ioctl_upload_server_if.master mem,
    output logic                  core_pause,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [PTR_W-1:0] SIZE_P = PTR_W'(SIZE);

    upl_state_t       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_n;
    logic             stale;   // outstanding request belongs to an address already consumed
    logic             sel;

    assign sel   = ioctl_upload && (ioctl_index == INDEX);
    assign ptr_n = ioctl_rd ? ptr_sat_inc(ptr, SIZE_P) : ptr;

    // Upload FSM; every output is registered here. IDLE is only reached with
    // sel low, so sel seen in IDLE is the upload start edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ioctl_din    <= PAD;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            core_pause   <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            ptr          <= '0;
            stale        <= 1'b0;
        end else if (!sel) begin
            ioctl_din <= PAD;
            if (state == FETCH && mem.mem_req && !mem.mem_ack) begin
                // never abandon a request: keep it up until the memory answers
                core_pause <= 1'b1;
                busy       <= 1'b1;
            end else begin
                state       <= IDLE;
                mem.mem_req <= 1'b0;
                busy        <= 1'b0;
                core_pause  <= 1'b0;
                stale       <= 1'b0;
            end
        end else begin
            core_pause <= 1'b1;
            case (state)
                IDLE: begin
                    state        <= FETCH;
                    ptr          <= '0;
                    overrun      <= 1'b0;
                    stale        <= 1'b0;
                    mem.mem_req  <= 1'b1;
                    mem.mem_addr <= '0;
                    busy         <= 1'b1;
                end
                FETCH: begin
                    ptr <= ptr_n;
                    if (ioctl_rd) overrun <= 1'b1;
                    if (mem.mem_req) begin
                        if (mem.mem_ack) begin
                            mem.mem_req <= 1'b0;
                            if (stale || ioctl_rd) begin
                                // data is for an old address; refetch after a one-cycle gap
                                stale <= 1'b0;
                            end else begin
                                ioctl_din <= mem.mem_data;
                                state     <= HOLD;
                                busy      <= 1'b0;
                            end
                        end else if (ioctl_rd) begin
                            stale <= 1'b1;
                        end
                    end else if (ptr_n >= SIZE_P) begin
                        ioctl_din <= PAD;
                        state     <= HOLD;
                        busy      <= 1'b0;
                    end else begin
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= ptr_n[AW-1:0];
                    end
                end
                HOLD: begin
                    if (ioctl_rd) begin
                        ptr <= ptr_n;
                        if (ptr_n >= SIZE_P) begin
                            ioctl_din <= PAD;
                        end else begin
                            state        <= FETCH;
                            busy         <= 1'b1;
                            mem.mem_req  <= 1'b1;
                            mem.mem_addr <= ptr_n[AW-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
